// File: rtl/finalproj_hpi_pio_pkg.sv
// finalproj_hpi_pio_pkg: register map, edge-type codes and pulse FSM states shared by the HPI PIO
package finalproj_hpi_pio_pkg;
  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_IN    = 3'd1;
  localparam logic [2:0] ADDR_SET   = 3'd2;
  localparam logic [2:0] ADDR_CLR   = 3'd3;
  localparam logic [2:0] ADDR_MASK  = 3'd4;
  localparam logic [2:0] ADDR_EDGE  = 3'd5;
  localparam logic [2:0] ADDR_PULSE = 3'd6;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
  typedef enum logic {PS_IDLE, PS_ACTIVE} pulse_state_e;
endpackage

// File: rtl/finalproj_soc_hpi_pio_if.sv
// finalproj_soc_hpi_pio_if: Avalon-MM slave bus between the Nios II data master and the PIO
interface finalproj_soc_hpi_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/finalproj_hpi_pio_edge.sv
// finalproj_hpi_pio_edge: input synchroniser with settle-gated edge detection
module finalproj_hpi_pio_edge
  import finalproj_hpi_pio_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int EDGE_TYPE  = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_in,
  output logic [DATA_WIDTH-1:0] o_sync,
  output logic [DATA_WIDTH-1:0] o_det
);
  logic [DATA_WIDTH-1:0] r_meta, r_sync, r_prev, w_rise, w_fall;
  logic [1:0] r_settle;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_prev   <= '0;
      r_settle <= '0;
    end else begin
      r_meta   <= i_in;
      r_sync   <= r_meta;
      r_prev   <= r_sync;
      r_settle <= (r_settle == 2'd3) ? r_settle : r_settle + 2'd1;
    end
  end
  assign w_rise = r_sync & ~r_prev;
  assign w_fall = ~r_sync & r_prev;
  assign o_sync = r_sync;
  // inputs already high at reset release would look like edges until the pipeline fills
  assign o_det  = (r_settle != 2'd3) ? '0 :
                  (EDGE_TYPE == EDGE_RISE) ? w_rise :
                  (EDGE_TYPE == EDGE_FALL) ? w_fall : (w_rise ^ w_fall);
endmodule

// File: rtl/finalproj_soc_hpi_pio.sv
// finalproj_soc_hpi_pio: Avalon PIO for HPI control pins with set/clear, strobe pulses and edge irq
module finalproj_soc_hpi_pio
  import finalproj_hpi_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int                    PULSE_CYCLES = 4,
  parameter int                    EDGE_TYPE    = EDGE_RISE
) (
  input  logic                      clk,
  input  logic                      reset,
  finalproj_soc_hpi_pio_if.slave    bus,
  input  logic [DATA_WIDTH-1:0]     in_port,
  output logic [DATA_WIDTH-1:0]     out_port,
  output logic                      irq
);
  logic [DATA_WIDTH-1:0] r_data, r_mask, r_edge, r_pmask, w_pmask_nx, w_wd, w_sync, w_det, w_w1c;
  logic [7:0]  r_pcnt, w_pcnt_nx;
  logic [31:0] w_rd;
  logic        w_wr, w_busy;
  pulse_state_e r_state, w_state_nx;

  finalproj_hpi_pio_edge #(.DATA_WIDTH(DATA_WIDTH), .EDGE_TYPE(EDGE_TYPE)) u_edge (
    .clk(clk), .reset(reset), .i_in(in_port), .o_sync(w_sync), .o_det(w_det)
  );

  assign w_wr   = bus.chipselect && !bus.write_n;
  assign w_wd   = bus.writedata[DATA_WIDTH-1:0];
  assign w_w1c  = (w_wr && bus.address == ADDR_EDGE) ? w_wd : '0;
  assign w_busy = (r_state == PS_ACTIVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= PS_IDLE;
      r_pmask <= '0;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pmask <= w_pmask_nx;
      r_pcnt  <= w_pcnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_pmask_nx = r_pmask;
    w_pcnt_nx  = r_pcnt;
    if (r_state == PS_IDLE) begin
      if (w_wr && bus.address == ADDR_PULSE && w_wd != '0) begin
        w_state_nx = PS_ACTIVE;
        w_pmask_nx = w_wd;
        w_pcnt_nx  = 8'(PULSE_CYCLES - 1);
      end
    end else if (r_pcnt == 8'd0) begin
      w_state_nx = PS_IDLE;
      w_pmask_nx = '0;
    end else begin
      w_pcnt_nx = r_pcnt - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= RESET_VALUE;
      r_mask <= '0;
      r_edge <= '0;
    end else begin
      r_data <= !w_wr                      ? r_data :
                bus.address == ADDR_DATA ? w_wd :
                bus.address == ADDR_SET  ? (r_data | w_wd) :
                bus.address == ADDR_CLR  ? (r_data & ~w_wd) : r_data;
      r_mask <= (w_wr && bus.address == ADDR_MASK) ? w_wd : r_mask;
      // a fresh detection outranks a simultaneous W1C of the same bit
      r_edge <= (r_edge & ~w_w1c) | w_det;
    end
  end

  always_comb begin
    w_rd = '0;
    case (bus.address)
      ADDR_DATA:  w_rd = 32'(r_data);
      ADDR_IN:    w_rd = 32'(w_sync);
      ADDR_MASK:  w_rd = 32'(r_mask);
      ADDR_EDGE:  w_rd = 32'(r_edge);
      ADDR_PULSE: w_rd = {16'd0, r_pcnt, 7'd0, w_busy};
      default:    w_rd = '0;
    endcase
  end

  assign bus.readdata = w_rd;
  assign out_port     = r_data ^ r_pmask;
  assign irq          = |(r_edge & r_mask);
endmodule

// File: doc/finalproj_soc_hpi_pio.md
Name: finalproj_soc_hpi_pio

Overview:
- Parametrised Avalon-MM slave PIO; next generation of the single-bit HPI control outputs (CS/RD/WR/RST) used toward the CY7C67200 OTG host port.
- Carries a DATA_WIDTH-bit output register with atomic set/clear writes, a self-timed pulse mode for HPI strobes, and a synchronised input port with edge capture and a maskable interrupt.
- Sits between the Nios II data master and the OTG HPI pins, one instance per control group.

Parameters:
- DATA_WIDTH, 8, width of out_port / in_port, legal 1..32.
- RESET_VALUE, 0, data_out value on reset; must fit in DATA_WIDTH bits.
- PULSE_CYCLES, 4, strobe length in clk cycles, legal 1..255.
- EDGE_TYPE, 0, edge detected on in_port: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word address of register.
- chipselect  in  1  Avalon select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above DATA_WIDTH ignored.
- readdata  out  32  read data, zero-extended, read latency 0.
- in_port  in  DATA_WIDTH  asynchronous external inputs.
- out_port  out  DATA_WIDTH  driven outputs.
- irq  out  1  level interrupt.

Behaviour:
- Write strobe is chipselect && !write_n, sampled on posedge clk. Reads are combinational from registers; no read side effects.
- Register map:
  - 0 DATA: R/W data_out.
  - 1 IN: R in_sync; writes ignored.
  - 2 SET: W, data_out |= wd.
  - 3 CLR: W, data_out &= ~wd.
  - 4 MASK: R/W irq_mask.
  - 5 EDGE: R edge_cap; W1C.
  - 6 PULSE: W starts a pulse; R bit0 = busy, bit[15:8] = remaining count.
  - 7: reserved; reads 0, writes ignored.
  - Reads of write-only addresses 2 and 3 return 0.
- Reset (asynchronous, immediate):
  - data_out = RESET_VALUE.
  - irq_mask, edge_cap, pulse_mask, pulse_cnt, busy, sync flops, settle counter = 0.
  - Outputs: out_port = RESET_VALUE, irq = 0.
  - A reset during an active pulse aborts it immediately.
- out_port = data_out ^ pulse_mask. pulse_mask is 0 whenever busy = 0.
- Pulse state machine (IDLE/ACTIVE):
  - IDLE: a write to PULSE with wd[DATA_WIDTH-1:0] != 0 loads pulse_mask = wd, pulse_cnt = PULSE_CYCLES-1, busy = 1, then moves to ACTIVE. A write of 0 is ignored.
  - ACTIVE: pulse_cnt decrements each cycle. In the cycle pulse_cnt == 0, the next edge clears pulse_mask and busy and returns to IDLE.
  - The inverted level lasts exactly PULSE_CYCLES cycles, starting the cycle after the write.
  - A PULSE write while busy is ignored; no restart or extension.
  - DATA/SET/CLR writes during ACTIVE update data_out; they show on out_port XOR the mask.
- Input path:
  - Two-flop synchroniser to in_sync, plus an in_prev flop.
  - Rising edge = in_sync & ~in_prev. Falling edge = ~in_sync & in_prev. Any = XOR of the two.
  - A 2-bit settle counter increments from 0 to 3 after reset and saturates. Edges are ignored until it reaches 3, which suppresses spurious captures after reset.
  - Latency: in_port change to edge_cap bit set is 3 clk edges.
- Edge capture: edge_cap <= (edge_cap & ~w1c) | det. If a W1C write and a new detection hit the same bit in the same cycle, the set wins.
- irq = |(edge_cap & irq_mask), combinational from flops and therefore glitch-free.
- Writes to DATA, SET and CLR in the same cycle cannot occur, since there is one address per access.

Decomposition:
- Shared package finalproj_hpi_pio_pkg holds:
  - address localparams ADDR_DATA..ADDR_PULSE (3-bit);
  - EDGE_RISE/EDGE_FALL/EDGE_ANY constants;
  - pulse state enum {PS_IDLE, PS_ACTIVE}.
- One sub-module, finalproj_hpi_pio_edge, parametrised by DATA_WIDTH and EDGE_TYPE. It contains the synchroniser, in_prev, settle counter and edge detect, and outputs in_sync and det.

Test Plan:
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata@0=32'h000000A5, irq=0, IN reads 0; then write DATA=8'h3C -> out_port=8'h3C next cycle.
- SET 8'h81 after DATA=8'h3C -> out_port 8'hBD; then CLR 8'h0F -> out_port 8'hB0; a read of address 2 returns 0.
- PULSE_CYCLES=4, DATA=8'h01, write PULSE 8'h01 -> out_port=8'h00 for exactly 4 cycles, then 8'h01; busy reads 1 and then 0; a second PULSE write mid-pulse leaves the length at 4.
- EDGE_TYPE=0, MASK=8'h04, in_port bit2 0->1 -> EDGE reads 8'h04 and irq=1 on the 3rd edge; W1C 8'h04 -> irq=0; a W1C coinciding with a new rising edge keeps the bit set.
- in_port=8'hFF held through reset release -> no EDGE bits set, irq stays 0; a toggle of bit0 at least 4 cycles later captures normally.
- Assert reset during an active pulse -> out_port returns to RESET_VALUE immediately and busy=0.
